// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the load/store stage.
// One request in flight; byte/half/word access with extension and error reporting.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          idle;
  logic          accept;
  logic          finish;
  logic          c_we;
  logic          c_uns;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [1:0]    c_size;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   rword;
  logic [31:0]   sh;
  logic [31:0]   rdata;
  logic [AW-1:0] widx;

  assign idle   = state == IDLE;
  assign accept = req_valid && req_ready;

  // A single-cycle build commits straight from the request inputs.
  assign c_we    = idle ? req_we       : we_q;
  assign c_addr  = idle ? req_addr     : addr_q;
  assign c_size  = idle ? req_size     : size_q;
  assign c_uns   = idle ? req_unsigned : uns_q;
  assign c_wdata = idle ? req_wdata    : wdata_q;

  assign finish = (idle && accept && LATENCY == 1)
               || (state == WAIT && cnt <= 4'd1);

  assign widx  = c_addr[AW+1:2];
  assign rword = mem[widx];
  assign sh    = rword >> {c_addr[1:0], 3'b000};

  always_comb begin
    err = c_addr[31:2] >= 30'(DEPTH_WORDS);
    unique case (c_size)
      2'b00: err = err;
      2'b01: err = err || c_addr[0];
      2'b10: err = err || (c_addr[1:0] != 2'b00);
      2'b11: err = 1'b1;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wword = c_wdata;
    unique case (c_size)
      2'b00: begin
        be    = 4'b0001 << c_addr[1:0];
        wword = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        be    = c_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{c_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      2'b11: be = 4'b0000;
    endcase
    if (err || !c_we) be = 4'b0000;
  end

  always_comb begin
    rdata = 32'b0;
    unique case (c_size)
      2'b00: rdata = c_uns ? {24'b0, sh[7:0]}
                           : {{24{sh[7]}}, sh[7:0]};
      2'b01: rdata = c_uns ? {16'b0, sh[15:0]}
                           : {{16{sh[15]}}, sh[15:0]};
      2'b10: rdata = rword;
      2'b11: rdata = 32'b0;
    endcase
    if (err || c_we) rdata = 32'b0;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (finish && reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'b0;
      size_q    <= 2'b0;
      uns_q     <= 1'b0;
      wdata_q   <= 32'b0;
    end else begin
      if (finish) begin
        state     <= RESP;
        cnt       <= 4'd0;
        req_ready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_rdata <= rdata;
        rsp_err   <= err;
      end else begin
        unique case (state)
          IDLE: begin
            req_ready <= 1'b1;
            if (accept) begin
              state     <= WAIT;
              cnt       <= CNT_INIT;
              req_ready <= 1'b0;
            end
          end
          WAIT: cnt <= cnt - 4'd1;
          RESP: begin
            if (rsp_ready) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              rsp_valid <= 1'b0;
              rsp_rdata <= 32'b0;
              rsp_err   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (idle && accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default build plus a LATENCY=1 build.
// Expected values are hand-computed from the memory behaviour.
module tb_dmem_responder;
  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        a_req_valid;
  logic        a_req_ready;
  logic        a_req_we;
  logic [31:0] a_req_addr;
  logic [1:0]  a_req_size;
  logic        a_req_unsigned;
  logic [31:0] a_req_wdata;
  logic        a_rsp_valid;
  logic        a_rsp_ready;
  logic [31:0] a_rsp_rdata;
  logic        a_rsp_err;

  int total = 0;
  int bad   = 0;

  dmem_responder u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned),
    .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] a,
                      input logic [1:0] sz, input logic un,
                      input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a;
    req_size = sz; req_unsigned = un; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_size = 2'b10; req_unsigned = 1'b0;
    req_wdata = '0; rsp_ready = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0;
    a_req_size = 2'b10; a_req_unsigned = 1'b0;
    a_req_wdata = '0; a_rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    xact(1, 32'h10, 2'b10, 0, 32'hDEADBEEF, rd, er, lat);
    chk("st_w_err", er, 0);
    chk("st_w_rdata", rd, 0);
    chk("st_w_lat", lat, 2);
    xact(0, 32'h10, 2'b10, 1, 0, rd, er, lat);
    chk("ld_w", rd, 32'hDEADBEEF);
    chk("ld_w_err", er, 0);
    chk("ld_w_lat", lat, 2);

    xact(1, 32'h13, 2'b00, 0, 32'h12345680, rd, er, lat);
    chk("st_b_err", er, 0);
    xact(0, 32'h13, 2'b00, 0, 0, rd, er, lat);
    chk("ld_b_s", rd, 32'hFFFFFF80);
    xact(0, 32'h13, 2'b00, 1, 0, rd, er, lat);
    chk("ld_b_u", rd, 32'h00000080);
    xact(0, 32'h10, 2'b10, 0, 0, rd, er, lat);
    chk("ld_w_merge", rd, 32'h80ADBEEF);
    xact(0, 32'h12, 2'b01, 0, 0, rd, er, lat);
    chk("ld_h_s", rd, 32'hFFFF80AD);
    xact(0, 32'h10, 2'b01, 1, 0, rd, er, lat);
    chk("ld_h_u", rd, 32'h0000BEEF);
    xact(0, 32'h10, 2'b00, 0, 0, rd, er, lat);
    chk("ld_b0_s", rd, 32'hFFFFFFEF);

    xact(0, 32'h11, 2'b01, 0, 0, rd, er, lat);
    chk("h_mis_err", er, 1);
    chk("h_mis_rdata", rd, 0);
    chk("h_mis_lat", lat, 2);
    xact(0, 32'h12, 2'b10, 0, 0, rd, er, lat);
    chk("w_mis_err", er, 1);
    xact(0, 32'h10, 2'b11, 0, 0, rd, er, lat);
    chk("sz11_err", er, 1);
    chk("sz11_rdata", rd, 0);

    xact(1, 32'h0, 2'b10, 0, 32'h11223344, rd, er, lat);
    xact(1, 32'h402, 2'b10, 0, 32'hAAAAAAAA, rd, er, lat);
    chk("oor_mis_err", er, 1);
    xact(1, 32'h400, 2'b10, 0, 32'h55555555, rd, er, lat);
    chk("oor_err", er, 1);
    xact(0, 32'h400, 2'b10, 0, 0, rd, er, lat);
    chk("oor_ld_err", er, 1);
    chk("oor_ld_rdata", rd, 0);
    xact(0, 32'h0, 2'b10, 0, 0, rd, er, lat);
    chk("no_alias", rd, 32'h11223344);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    req_size = 2'b10; req_unsigned = 1'b0;
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 32'h80ADBEEF);
      chk("stall_ready", req_ready, 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_ready", req_ready, 1);
    chk("post_hs_valid", rsp_valid, 0);
    xact(0, 32'h10, 2'b10, 0, 0, rd, er, lat);
    chk("ignored_store", rd, 32'h80ADBEEF);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    req_size = 2'b10;
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    #2 reset = 1'b0;
    #1;
    chk("rst_resp_valid", rsp_valid, 0);
    chk("rst_resp_rdata", rsp_rdata, 0);
    chk("rst_resp_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b1;

    xact(1, 32'h20, 2'b10, 0, 32'hCAFEF00D, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_size = 2'b10; req_wdata = 32'h12345678;
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_wait_valid", rsp_valid, 0);
    chk("rst_wait_err", rsp_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    xact(0, 32'h20, 2'b10, 0, 0, rd, er, lat);
    chk("store_dropped", rd, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h4;
    a_req_size = 2'b10; a_req_wdata = 32'h5A5A0001;
    for (int i = 0; i < 8; i++) begin
      chk("l1_accept", a_req_valid && a_req_ready, (i % 2 == 0));
      chk("l1_valid", a_rsp_valid, (i % 2 == 1));
      if (i == 3) begin
        chk("l1_rdata", a_rsp_rdata, 32'h5A5A0001);
        chk("l1_err", a_rsp_err, 0);
      end
      @(negedge clk);
      if (i == 0) a_req_we = 1'b0;
    end
    a_req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit words of backing storage (power of two, 16..4096).
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from request acceptance to first rsp_valid (legal range 1..15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  pipeline load/store request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  pipeline accepts response.
REQ-014 rsp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  misaligned, illegal size, or out-of-range access.

Function
REQ-016 FSM SHALL have states IDLE, WAIT, RESP; one outstanding request at most.
REQ-017 req_ready SHALL be 1 only in IDLE; acceptance = req_valid && req_ready, capturing we, addr, size, unsigned, wdata.
REQ-018 On acceptance: IDLE -> WAIT with latency counter loaded to LATENCY-1; if LATENCY = 1, IDLE -> RESP directly.
REQ-019 WAIT SHALL decrement the counter each cycle; at 0 it SHALL move to RESP, giving rsp_valid exactly LATENCY cycles after the acceptance edge.
REQ-020 RESP SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_valid && rsp_ready, then go to IDLE; req_ready rises the cycle after, with no same-cycle back-to-back.
REQ-021 Error if: size = 11; half with addr[0] = 1; word with addr[1:0] != 0; word index addr[31:2] >= DEPTH_WORDS.
REQ-022 Error access SHALL NOT modify storage, SHALL return rsp_rdata = 0 and rsp_err = 1, with the same latency as a normal access.
REQ-023 Store SHALL be committed on the WAIT/IDLE -> RESP transition edge, writing only the addressed lanes: byte at addr[1:0] from wdata[7:0]; half at addr[1] from wdata[15:0]; word from wdata[31:0].
REQ-024 Load SHALL read the addressed lane(s) at the RESP transition edge and extend to 32 bits per req_size/req_unsigned.
REQ-025 A load issued after a store to the same address SHALL return the stored value.
REQ-026 Request inputs outside IDLE SHALL be ignored.
REQ-027 Storage SHALL be synthesizable as one array; byte-lane write enables are derived internally.

Reset
REQ-028 While reset = 0: state = IDLE, counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-029 req_ready SHALL rise on the first clock edge after reset deasserts.
REQ-030 Storage contents SHALL NOT be cleared by reset; a store whose commit edge has not occurred when reset asserts SHALL be dropped.
REQ-031 Reset asserted in WAIT or RESP SHALL drop the pending response immediately and asynchronously.

Verification
REQ-032 Word store 0xDEADBEEF @0x10, then word load @0x10 unsigned -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid 2 cycles after each acceptance.
REQ-033 Byte store 0x80 @0x13, then signed byte load @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load @0x10 -> 0x80ADBEEF.
REQ-034 Half load @0x11 -> rsp_err = 1, rsp_rdata = 0; word store @0x402 with DEPTH_WORDS = 256 -> rsp_err = 1 and @0x400 unchanged; req_size = 11 -> rsp_err = 1.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and data stable throughout, req_ready = 0; a new req_valid is ignored.
REQ-036 reset pulsed low during WAIT of a store 0x12345678 @0x20 -> outputs zero immediately; a later load @0x20 returns the pre-store value.
REQ-037 LATENCY = 1 build: back-to-back requests -> rsp_valid 1 cycle after acceptance; acceptances at least 2 cycles apart with rsp_ready tied to 1.
